// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared constants and helpers for the single-clock FIFO family.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Ceiling log2; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Legal when 1 <= af <= depth and 0 <= ae <= depth-1.
  function automatic bit thresholds_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Brief    : Simple dual-port storage array, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADD_BITS-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADD_BITS-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int c_depth = 1 << ADD_BITS;

  logic [DATA_WIDTH-1:0] mem_q [c_depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl
// Brief    : Single-clock FIFO with fill count, thresholds, STD/FWFT read,
//            flush and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_BITS   = 3,
  parameter int FWFT       = FIFO_STD,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADD_BITS:0]     count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_sticky,
  output logic                  udf_sticky
);

  localparam int                c_depth   = 1 << ADD_BITS;
  localparam int                c_cnt_w   = ADD_BITS + 1;
  localparam logic [ADD_BITS:0] c_cnt_max = c_cnt_w'(c_depth);
  localparam logic [ADD_BITS:0] c_af      = c_cnt_w'(AF_LEVEL);
  localparam logic [ADD_BITS:0] c_ae      = c_cnt_w'(AE_LEVEL);

  if (!thresholds_ok(c_depth, AF_LEVEL, AE_LEVEL)) begin : g_bad_thresholds
    $fatal(1, "sync_fifo_ctrl: AF_LEVEL or AE_LEVEL outside legal range");
  end

  if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
    $fatal(1, "sync_fifo_ctrl: FWFT must be FIFO_STD or FIFO_FWFT");
  end

  logic [ADD_BITS-1:0]   wptr_q, wptr_d;
  logic [ADD_BITS-1:0]   rptr_q, rptr_d;
  logic [ADD_BITS:0]     count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  ovf_sticky_q, ovf_sticky_d;
  logic                  udf_sticky_q, udf_sticky_d;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_full  = (count_q == c_cnt_max);
  assign w_empty = (count_q == '0);

  // Flush suppresses every accept and every error event in its cycle.
  assign w_rd_ok   = ren && !w_empty && !flush;
  assign w_wr_ok   = wen && (!w_full || w_rd_ok) && !flush;
  assign w_ovf_evt = wen && !w_wr_ok && !flush;
  assign w_udf_evt = ren && w_empty && !flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADD_BITS   (ADD_BITS)
  ) u_mem (
    .clk     (clk),
    .we_i    (w_wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (w_mem_rdata)
  );

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    ovf_d        = w_ovf_evt;
    udf_d        = w_udf_evt;
    ovf_sticky_d = ovf_sticky_q;
    udf_sticky_d = udf_sticky_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (w_wr_ok) wptr_d = wptr_q + 1'b1;
      if (w_rd_ok) rptr_d = rptr_q + 1'b1;
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Set wins over a same-cycle clear so no error event is ever lost.
    if (clr_err) begin
      ovf_sticky_d = 1'b0;
      udf_sticky_d = 1'b0;
    end
    if (w_ovf_evt) ovf_sticky_d = 1'b1;
    if (w_udf_evt) udf_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rdata  = w_mem_rdata;
    assign rvalid = !w_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = w_rd_ok;
      if (w_rd_ok) rdata_d = w_mem_rdata;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (count_q >= c_af);
  assign almost_empty = (count_q <= c_ae);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign ovf_sticky   = ovf_sticky_q;
  assign udf_sticky   = udf_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ctrl
// Brief    : Directed bench; one standard-mode and one FWFT instance share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst, flush, clr_err, wen, ren;
  logic [7:0] wdata;

  logic [7:0] s_rdata, f_rdata;
  logic       s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_ovfs, s_udfs;
  logic       f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_ovfs, f_udfs;
  logic [3:0] s_count, f_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .ADD_BITS(3), .FWFT(FIFO_STD), .AF_LEVEL(6), .AE_LEVEL(1)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wen(wen),
    .wdata(wdata), .ren(ren), .rdata(s_rdata), .rvalid(s_rvalid),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf),
    .ovf_sticky(s_ovfs), .udf_sticky(s_udfs)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .ADD_BITS(3), .FWFT(FIFO_FWFT), .AF_LEVEL(6), .AE_LEVEL(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wen(wen),
    .wdata(wdata), .ren(ren), .rdata(f_rdata), .rvalid(f_rvalid),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf),
    .ovf_sticky(f_ovfs), .udf_sticky(f_udfs)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wen   = 1'b1;
    wdata = d;
    tick();
    wen   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr_err = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_count",  32'(s_count), 32'd0);
    chk("rst_empty",  32'(s_empty), 32'd1);
    chk("rst_full",   32'(s_full),  32'd0);
    chk("rst_ae",     32'(s_ae),    32'd1);
    chk("rst_af",     32'(s_af),    32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_rdata",  32'(s_rdata), 32'd0);
    chk("rst_errs",   32'({s_ovf, s_udf, s_ovfs, s_udfs}), 32'd0);
    chk("rst_fwft_rvalid", 32'(f_rvalid), 32'd0);

    // Fill 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      push(8'(8'h10 + i));
      chk("fill_count", 32'(s_count), 32'(i + 1));
      chk("fill_af",    32'(s_af),    32'((i + 1) >= 6));
      chk("fill_ae",    32'(s_ae),    32'((i + 1) <= 1));
    end
    chk("fill_full", 32'(s_full), 32'd1);

    // Drain with continuous ren; data lags ren by one cycle
    ren = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("drain_rvalid", 32'(s_rvalid), 32'd1);
      chk("drain_rdata",  32'(s_rdata),  32'(8'h10 + k));
      chk("drain_count",  32'(s_count),  32'(7 - k));
      chk("drain_ae",     32'(s_ae),     32'((7 - k) <= 1));
    end
    ren = 1'b0;
    tick();
    chk("drain_rvalid_end", 32'(s_rvalid), 32'd0);
    chk("drain_rdata_hold", 32'(s_rdata),  32'h17);
    chk("drain_empty",      32'(s_empty),  32'd1);

    // Overflow on a full FIFO
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    push(8'hAA);
    chk("ovf_count",  32'(s_count), 32'd8);
    chk("ovf_pulse",  32'(s_ovf),   32'd1);
    chk("ovf_sticky", 32'(s_ovfs),  32'd1);
    tick();
    chk("ovf_pulse_end",   32'(s_ovf),  32'd0);
    chk("ovf_sticky_hold", 32'(s_ovfs), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_sticky_clr", 32'(s_ovfs), 32'd0);

    // Simultaneous read+write while full
    wen = 1'b1; ren = 1'b1; wdata = 8'h55;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("frw_count",  32'(s_count),  32'd8);
    chk("frw_ovf",    32'(s_ovf),    32'd0);
    chk("frw_rdata",  32'(s_rdata),  32'h20);
    chk("frw_rvalid", 32'(s_rvalid), 32'd1);
    ren = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("frw_drain", 32'(s_rdata), (k < 7) ? 32'(8'h21 + k) : 32'h55);
    end
    ren = 1'b0;
    tick();
    chk("frw_empty", 32'(s_empty), 32'd1);

    // Underflow and sticky set-over-clear priority
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("udf_pulse",  32'(s_udf),    32'd1);
    chk("udf_sticky", 32'(s_udfs),   32'd1);
    chk("udf_rvalid", 32'(s_rvalid), 32'd0);
    tick();
    chk("udf_pulse_end", 32'(s_udf), 32'd0);
    ren = 1'b1; clr_err = 1'b1;
    tick();
    ren = 1'b0;
    chk("udf_set_wins", 32'(s_udfs), 32'd1);
    tick();
    clr_err = 1'b0;
    chk("udf_sticky_clr", 32'(s_udfs), 32'd0);

    // 20 write/read pairs wrap the pointers twice
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'(i * 7 + 3);
      push(d);
      ren = 1'b1;
      tick();
      ren = 1'b0;
      chk("wrap_rdata",  32'(s_rdata),  32'(d));
      chk("wrap_rvalid", 32'(s_rvalid), 32'd1);
      chk("wrap_count",  32'(s_count),  32'd0);
    end

    // FWFT: word visible the cycle after its write without ren
    push(8'h3C);
    chk("fwft_empty",   32'(f_empty),  32'd0);
    chk("fwft_rvalid",  32'(f_rvalid), 32'd1);
    chk("fwft_rdata",   32'(f_rdata),  32'h3C);
    chk("std_no_rvalid", 32'(s_rvalid), 32'd0);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("fwft_pop_empty",  32'(f_empty),  32'd1);
    chk("fwft_pop_rvalid", 32'(f_rvalid), 32'd0);
    chk("std_pop_rdata",   32'(s_rdata),  32'h3C);
    push(8'h41);
    push(8'h42);
    chk("fwft_head1", 32'(f_rdata), 32'h41);
    chk("fwft_cnt2",  32'(f_count), 32'd2);
    ren = 1'b1;
    tick();
    chk("fwft_head2", 32'(f_rdata),  32'h42);
    chk("fwft_rv2",   32'(f_rvalid), 32'd1);
    tick();
    ren = 1'b0;
    chk("fwft_drained", 32'(f_empty), 32'd1);
    chk("std_last",     32'(s_rdata), 32'h42);

    // Flush with wen/ren in the same cycle; sticky survives flush
    ren = 1'b1;
    tick();
    ren = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    chk("pre_flush_count", 32'(s_count), 32'd5);
    flush = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 8'h99;
    tick();
    flush = 1'b0; wen = 1'b0; ren = 1'b0;
    chk("flush_count",  32'(s_count),  32'd0);
    chk("flush_empty",  32'(s_empty),  32'd1);
    chk("flush_errs",   32'({s_ovf, s_udf}), 32'd0);
    chk("flush_rvalid", 32'(s_rvalid), 32'd0);
    chk("flush_rdata",  32'(s_rdata),  32'h42);
    chk("flush_sticky", 32'(s_udfs),   32'd1);
    chk("flush_fcount", 32'(f_count),  32'd0);
    push(8'h77);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("post_flush_rdata", 32'(s_rdata), 32'h77);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) push(8'(8'h81 + i));
    ren = 1'b1;
    tick();
    chk("pre_rst_rvalid", 32'(s_rvalid), 32'd1);
    rst = 1'b1; wen = 1'b1;
    tick();
    rst = 1'b0; wen = 1'b0; ren = 1'b0;
    chk("mrst_count",  32'(s_count),  32'd0);
    chk("mrst_rdata",  32'(s_rdata),  32'd0);
    chk("mrst_rvalid", 32'(s_rvalid), 32'd0);
    chk("mrst_flags",  32'({s_empty, s_full, s_ae, s_af}), 32'b1010);
    chk("mrst_errs",   32'({s_ovf, s_udf, s_ovfs, s_udfs}), 32'd0);
    chk("mrst_fwft",   32'({f_empty, f_rvalid}), 32'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
